// File: rtl/img_mem_sequencer.sv
// Job sequencer and RAM arbiter for the image downsampling processor:
// host load, processor run, host unload, with a single RAM owner per phase.
module img_mem_sequencer #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 8,
  parameter int IMG_IN_WORDS  = 16384,
  parameter int OUT_BASE      = 16384,
  parameter int IMG_OUT_WORDS = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              host_wr_valid,
  input  logic [DATA_W-1:0] host_wr_data,
  output logic              host_wr_ready,
  output logic              host_rd_valid,
  output logic [DATA_W-1:0] host_rd_data,
  input  logic              host_rd_ready,
  output logic              enable,
  input  logic              finish,
  input  logic              proc_mem_rd,
  input  logic              proc_mem_wr,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [DATA_W-1:0] proc_wdata,
  output logic [DATA_W-1:0] proc_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [2:0]        state,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_UREAD = 3'd3,
    S_UHOLD = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [ADDR_W:0]   LOAD_LAST  = (ADDR_W+1)'(IMG_IN_WORDS - 1);
  localparam logic [ADDR_W:0]   OUT_LAST   = (ADDR_W+1)'(IMG_OUT_WORDS - 1);
  localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] OUT_BASE_A = ADDR_W'(OUT_BASE);

  state_t            state_q;
  logic [ADDR_W:0]   load_cnt;
  logic [ADDR_W:0]   rd_cnt;
  logic [DATA_W-1:0] rd_data_q;
  logic              uhold_first;
  logic              proto_err;

  assign state         = state_q;
  assign host_wr_ready = (state_q == S_LOAD);
  assign proc_rdata    = ram_rdata;

  // RAM data is only valid in the first UHOLD cycle; pass it through then,
  // and present the captured copy for as long as the host stalls.
  assign host_rd_data = uhold_first ? ram_rdata : rd_data_q;

  always_comb begin
    proto_err = 1'b0;
    if (state_q == S_RUN) proto_err = proc_mem_rd & proc_mem_wr;
    else                  proto_err = proc_mem_rd | proc_mem_wr;
  end

  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    case (state_q)
      S_LOAD: begin
        ram_addr  = load_cnt[ADDR_W-1:0];
        ram_wdata = host_wr_data;
        ram_we    = host_wr_valid;
      end
      S_RUN: begin
        ram_addr  = proc_addr;
        ram_wdata = proc_wdata;
        ram_we    = proc_mem_wr;
        ram_re    = proc_mem_rd & ~proc_mem_wr;
      end
      S_UREAD: begin
        ram_addr = OUT_BASE_A + rd_cnt[ADDR_W-1:0];
        ram_re   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      load_cnt      <= '0;
      rd_cnt        <= '0;
      rd_data_q     <= '0;
      uhold_first   <= 1'b0;
      enable        <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      host_rd_valid <= 1'b0;
    end else begin
      if (proto_err) err <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q  <= S_LOAD;
            load_cnt <= '0;
            rd_cnt   <= '0;
          end
        end
        S_LOAD: begin
          if (host_wr_valid) begin
            load_cnt <= load_cnt + CNT_ONE;
            if (load_cnt == LOAD_LAST) begin
              state_q <= S_RUN;
              enable  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (finish) begin
            state_q <= S_UREAD;
            enable  <= 1'b0;
            rd_cnt  <= '0;
          end
        end
        S_UREAD: begin
          state_q       <= S_UHOLD;
          host_rd_valid <= 1'b1;
          uhold_first   <= 1'b1;
        end
        S_UHOLD: begin
          uhold_first <= 1'b0;
          if (uhold_first) rd_data_q <= ram_rdata;
          if (host_rd_ready) begin
            host_rd_valid <= 1'b0;
            if (rd_cnt == OUT_LAST) begin
              state_q <= S_DONE;
              done    <= 1'b1;
            end else begin
              rd_cnt  <= rd_cnt + CNT_ONE;
              state_q <= S_UREAD;
            end
          end
        end
        S_DONE: begin
          if (start) begin
            state_q  <= S_LOAD;
            done     <= 1'b0;
            load_cnt <= '0;
            rd_cnt   <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/img_mem_sequencer.md
Name: img_mem_sequencer

Overview:
- Owns the single-port data RAM of the image downsampling processor.
- Sequences the three phases of a job:
  - LOAD: the host streams the input image into RAM.
  - RUN: the RAM is handed to the processor, and the control unit is enabled until it signals finish.
  - UNLOAD: the downsampled image is streamed back to the host.
- Acts as the arbiter between the host and the processor: only one owner drives the RAM in any phase.

Parameters:
ADDR_W, 16, RAM address width
DATA_W, 8, pixel/word width
IMG_IN_WORDS, 16384, input pixels loaded from address 0 (128x128)
OUT_BASE, 16384, first RAM address of the output image
IMG_OUT_WORDS, 4096, output pixels unloaded (64x64)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous active-high reset
start  input  1  begin a job; sampled in IDLE/DONE only
host_wr_valid  input  1  loader pixel valid
host_wr_data  input  DATA_W  loader pixel
host_wr_ready  output  1  sequencer accepts loader pixel
host_rd_valid  output  1  unload pixel valid
host_rd_data  output  DATA_W  unload pixel
host_rd_ready  input  1  host accepts unload pixel
enable  output  1  to control unit enable
finish  input  1  from control unit finish (level, sticky)
proc_mem_rd  input  1  processor data read request
proc_mem_wr  input  1  processor data write request
proc_addr  input  ADDR_W  processor address
proc_wdata  input  DATA_W  processor write data
proc_rdata  output  DATA_W  RAM read data to processor
ram_addr  output  ADDR_W  RAM address
ram_wdata  output  DATA_W  RAM write data
ram_we  output  1  RAM write strobe
ram_re  output  1  RAM read strobe
ram_rdata  input  DATA_W  RAM read data, valid 1 cycle after ram_re
state  output  3  IDLE=0 LOAD=1 RUN=2 UREAD=3 UHOLD=4 DONE=5
done  output  1  high in DONE
err  output  1  sticky protocol error

Behaviour:
- Reset:
  - state=IDLE; load_cnt=rd_cnt=0; err=0.
  - All outputs are 0, including enable, ram_we, ram_re, host_rd_valid and host_rd_data.
  - Reset is asynchronous: enable drops immediately, mid-job included. Any partial job is abandoned.
- IDLE:
  - start=1 -> LOAD; load_cnt cleared.
- LOAD:
  - host_wr_ready=1.
  - On valid&ready: ram_we=1, ram_addr=load_cnt, ram_wdata=host_wr_data (combinational, same cycle); load_cnt+1.
  - When the accepted word has load_cnt==IMG_IN_WORDS-1 -> RUN next cycle.
  - host_wr_ready=0 in every other state; host writes are ignored there.
- RUN:
  - enable=1, registered: high from the first RUN cycle.
  - RAM ports pass combinationally from the processor: ram_addr=proc_addr, ram_we=proc_mem_wr, ram_re=proc_mem_rd, ram_wdata=proc_wdata.
  - proc_rdata=ram_rdata in all states; the processor samples it one cycle after ram_re.
  - proc_mem_rd&proc_mem_wr in the same cycle: the write is performed, the read is suppressed, and err is set.
  - finish=1 -> UREAD next cycle, rd_cnt=0. enable=0 from that cycle, and processor strobes are no longer forwarded.
- Processor strobes outside RUN: never reach the RAM; err is set.
- UREAD:
  - ram_re=1, ram_addr=OUT_BASE+rd_cnt (ADDR_W wrap-around, modulo 2^ADDR_W) -> UHOLD.
- UHOLD:
  - host_rd_data is captured from ram_rdata on entry.
  - host_rd_valid=1; data is held stable until host_rd_ready.
  - On valid&ready: if rd_cnt==IMG_OUT_WORDS-1 -> DONE, else rd_cnt+1 -> UREAD.
  - Throughput is 1 pixel per 2 cycles minimum.
- DONE:
  - done=1.
  - start=1 -> LOAD; counters cleared, done drops next cycle. err is not cleared by start (reset only).
- start in LOAD/RUN/UREAD/UHOLD is ignored.
- finish already high on entry to RUN: RUN lasts exactly 1 cycle (enable high for 1 cycle), then UREAD.
- Counters are ADDR_W+1 bits wide, so IMG_IN_WORDS=2^ADDR_W is legal.

Test Plan:
1. Bench parameters: IMG_IN_WORDS=16, OUT_BASE=16, IMG_OUT_WORDS=4, with a behavioural RAM model.
2. Reset, start pulse, stream pixels 0x10..0x1F with valid held high -> 16 consecutive ram_we at addresses 0..15; state=RUN on the cycle after the 16th accept; enable=1.
3. In RUN, the model processor writes 0xA0..0xA3 to 16..19, then asserts finish -> enable=0 the next cycle; host_rd_data sequence A0,A1,A2,A3; done=1 after the 4th handshake.
4. Unload backpressure: host_rd_ready low for 5 cycles on the 2nd pixel -> host_rd_valid stays high, data stable at A1, no extra ram_re issued; pixel order is unchanged after release.
5. Assert rst mid-LOAD after 7 accepts -> state=0 and host_wr_ready=0 immediately; a new start restarts loading at address 0.
6. Processor drives proc_mem_rd=proc_mem_wr=1 in RUN -> write performed, ram_re=0, err=1. Also assert proc_mem_wr in LOAD -> ram_we driven only by the host and err stays 1 until rst.
